// File: rtl/key_debounce.sv
// Per-key debouncer with one-cycle press/release strobes for active-low pushbuttons.
// Optional auto-repeat on held keys is enabled by defining KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_db,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("key_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] done;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] rep_fire;

  // A level is accepted once the synchronized input has disagreed with key_db
  // for DEBOUNCE_CYCLES consecutive samples; done marks that accepting edge.
  always_comb begin
    differ = s2 ^ key_db;
    done   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      done[i] = differ[i] && (cnt[i] == CNT_MAX);
    end
    fall = done & key_db;
    rise = done & ~key_db;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1          <= '1;
      s2          <= '1;
      key_db      <= '1;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= key_raw;
      s2          <= s1;
      key_db      <= key_db ^ done;
      key_press   <= fall | rep_fire;
      key_release <= rise;
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || done[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] DLY_MAX = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PER_MAX = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  rep_state_t     state      [WIDTH];
  rep_state_t     state_next [WIDTH];
  logic [RCW-1:0] rcnt       [WIDTH];
  logic [RCW-1:0] rcnt_next  [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        rcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_next[i];
        rcnt[i]  <= rcnt_next[i];
      end
    end
  end

  // Release acceptance wins over a coincident repeat, so no strobe on that edge.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      rcnt_next[i]  = rcnt[i] + RCW'(1);
      case (state[i])
        IDLE: begin
          rcnt_next[i] = '0;
          if (fall[i]) begin
            state_next[i] = DELAY;
          end
        end
        DELAY: begin
          if (rise[i]) begin
            state_next[i] = IDLE;
            rcnt_next[i]  = '0;
          end else if (rcnt[i] == DLY_MAX) begin
            state_next[i] = REPEAT;
            rcnt_next[i]  = '0;
            rep_fire[i]   = 1'b1;
          end
        end
        REPEAT: begin
          if (rise[i]) begin
            state_next[i] = IDLE;
            rcnt_next[i]  = '0;
          end else if (rcnt[i] == PER_MAX) begin
            rcnt_next[i]  = '0;
            rep_fire[i]   = 1'b1;
          end
        end
        default: begin
          state_next[i] = IDLE;
          rcnt_next[i]  = '0;
        end
      endcase
    end
  end
`else
  assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (WIDTH=4, DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_PERIOD=6); repeat expectations follow KEY_DEBOUNCE_AUTOREPEAT_EN.
module tb_key_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [3:0] key_db;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int vectors;
  int miscompares;
  int press_cnt   [4];
  int release_cnt [4];
  int overlap_cnt;
  int base;
  int base_rel;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  key_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(6)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .key_db(key_db),
    .key_press(key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe tally sampled on the falling edge, away from the active edge.
  initial begin
    overlap_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]   = 0;
      release_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i])   press_cnt[i]++;
      if (key_release[i]) release_cnt[i]++;
    end
    if ((key_press & key_release) != 4'b0000) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive key_raw just after an active edge, then advance n edges and settle 1 ns.
  task automatic applyStimulus(input logic [3:0] raw, input int n);
    key_raw = raw;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    key_raw     = 4'b1111;
    #12;
    checkOutput("reset_db", 32'(key_db), 32'hF);
    checkOutput("reset_press", 32'(key_press), 32'h0);
    checkOutput("reset_release", 32'(key_release), 32'h0);
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b1111, 3);

    // Clean press of key 0
    applyStimulus(4'b1110, 9);
    checkOutput("t1_db_before", 32'(key_db), 32'hF);
    applyStimulus(4'b1110, 1);
    checkOutput("t1_db_accept", 32'(key_db), 32'hE);
    checkOutput("t1_press", 32'(key_press), 32'h1);
    checkOutput("t1_release_quiet", 32'(key_release), 32'h0);
    applyStimulus(4'b1110, 1);
    checkOutput("t1_press_one_cycle", 32'(key_press), 32'h0);
    applyStimulus(4'b1111, 10);
    checkOutput("t1_release", 32'(key_release), 32'h1);
    checkOutput("t1_db_released", 32'(key_db), 32'hF);
    applyStimulus(4'b1111, 5);

    // Bouncing key 1
    base = press_cnt[1];
    for (int seg = 0; seg < 10; seg++) begin
      applyStimulus((seg % 2 == 0) ? 4'b1101 : 4'b1111, 3);
      checkOutput("t2_db_bouncing", 32'(key_db), 32'hF);
    end
    applyStimulus(4'b1101, 9);
    checkOutput("t2_db_before", 32'(key_db), 32'hF);
    checkOutput("t2_no_early_press", 32'(press_cnt[1] - base), 32'd0);
    applyStimulus(4'b1101, 1);
    checkOutput("t2_db_accept", 32'(key_db), 32'hD);
    checkOutput("t2_press", 32'(key_press), 32'h2);
    applyStimulus(4'b1101, 5);
    checkOutput("t2_press_count", 32'(press_cnt[1] - base), 32'd1);
    applyStimulus(4'b1111, 15);

    // Seven-cycle glitch on key 2
    base     = press_cnt[2];
    base_rel = release_cnt[2];
    applyStimulus(4'b1011, 7);
    applyStimulus(4'b1111, 12);
    checkOutput("t3_db", 32'(key_db), 32'hF);
    checkOutput("t3_press_count", 32'(press_cnt[2] - base), 32'd0);
    checkOutput("t3_release_count", 32'(release_cnt[2] - base_rel), 32'd0);

    // All keys together
    applyStimulus(4'b0000, 9);
    checkOutput("t4_db_before", 32'(key_db), 32'hF);
    applyStimulus(4'b0000, 1);
    checkOutput("t4_db_accept", 32'(key_db), 32'h0);
    checkOutput("t4_press", 32'(key_press), 32'hF);
    applyStimulus(4'b0000, 1);
    checkOutput("t4_press_one_cycle", 32'(key_press), 32'h0);
    applyStimulus(4'b0000, 38);
    applyStimulus(4'b1111, 10);
    checkOutput("t4_release", 32'(key_release), 32'hF);
    checkOutput("t4_db_released", 32'(key_db), 32'hF);
    applyStimulus(4'b1111, 1);
    checkOutput("t4_release_one_cycle", 32'(key_release), 32'h0);
    applyStimulus(4'b1111, 5);

    // Reset in the middle of a count on key 0
    applyStimulus(4'b1110, 6);
    reset_n = 1'b0;
    #2;
    checkOutput("t5_db_in_reset", 32'(key_db), 32'hF);
    checkOutput("t5_press_in_reset", 32'(key_press), 32'h0);
    checkOutput("t5_release_in_reset", 32'(key_release), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(4'b1110, 9);
    checkOutput("t5_db_before", 32'(key_db), 32'hF);
    applyStimulus(4'b1110, 1);
    checkOutput("t5_db_accept", 32'(key_db), 32'hE);
    checkOutput("t5_press", 32'(key_press), 32'h1);
    applyStimulus(4'b1111, 15);

    // Held key 3 with optional auto-repeat
    base     = press_cnt[3];
    base_rel = release_cnt[3];
    applyStimulus(4'b0111, 10);
    checkOutput("t6_press_accept", 32'(key_press), 32'h8);
    applyStimulus(4'b0111, 20);
    checkOutput("t6_first_repeat", 32'(key_press), (REP_ON != 0) ? 32'h8 : 32'h0);
    applyStimulus(4'b0111, 40);
    applyStimulus(4'b1111, 10);
    checkOutput("t6_db_released", 32'(key_db), 32'hF);
    checkOutput("t6_release", 32'(key_release), 32'h8);
    checkOutput("t6_no_press_on_release", 32'(key_press), 32'h0);
    applyStimulus(4'b1111, 20);
    checkOutput("t6_press_count", 32'(press_cnt[3] - base), (REP_ON != 0) ? 32'd10 : 32'd1);
    checkOutput("t6_release_count", 32'(release_cnt[3] - base_rel), 32'd1);

    checkOutput("press_release_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Per-bit debouncer and edge-pulse generator for the board pushbuttons.
- Sits directly upstream of the key PIO: key_db drives the PIO's 4-bit input port, so software sees clean levels and edge capture fires once per physical press.
- Also exports one-cycle press/release strobes for hardware consumers.
- Pushbuttons are active-low: idle = 1, pressed = 0.

Parameters:
WIDTH, 4, number of keys.
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a new level (20 ms at 50 MHz); legal minimum 2. Counter width is derived internally as clog2(DEBOUNCE_CYCLES+1).
REPEAT_DELAY, 25000000, cycles from the first press strobe to the first auto-repeat strobe (used only with the optional feature).
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat strobes (used only with the optional feature).

Ports:
clk  input  1  system clock; single clock domain.
reset_n  input  1  asynchronous, active-low reset.
key_raw  input  WIDTH  raw pushbutton pins; asynchronous to clk, active-low.
key_db  output  WIDTH  debounced level, same polarity as key_raw.
key_press  output  WIDTH  one-cycle strobe when a key is accepted as pressed (key_db 1->0).
key_release  output  WIDTH  one-cycle strobe when a key is accepted as released (key_db 0->1).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, named reset_n.
- Reset values:
  - key_db = all ones.
  - key_press, key_release = 0.
  - Synchronizer flops = all ones.
  - All counters = 0.
  - Repeat FSMs in IDLE.
- Synchronizer: 2-flop chain per bit (s1, s2), clocked every cycle.
- Per-bit debounce counter cnt[i]:
  - s2[i] == key_db[i]: cnt <= 0. Any glitch restarts the count.
  - s2[i] != key_db[i] and cnt == DEBOUNCE_CYCLES-1: key_db[i] toggles, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Latency: key_raw[i] changes before edge k and stays stable. key_db[i] changes at edge k+1+DEBOUNCE_CYCLES.
- Strobes:
  - key_press[i] and key_release[i] are registered and assert at the same edge key_db[i] toggles.
  - Each is high for exactly one cycle and is 0 otherwise.
  - press and release for one bit are never high together.
- Independence: bits are fully independent. Any combination of keys may toggle or strobe in the same cycle.
- Reset mid-operation: all counts are lost and key_db returns to all ones.
  - A key held through reset is re-accepted as pressed at edge 2+DEBOUNCE_CYCLES after reset_n deasserts (synchronous-deassert timing is the integrator's responsibility).
  - That acceptance produces a key_press strobe.
- No bus interface and no software-visible registers.

Optional Feature:
Macro: KEY_DEBOUNCE_AUTOREPEAT_EN
- Defined: each key gets a 3-state FSM plus a repeat counter.
  - IDLE -> DELAY on key_press[i]; counter cleared.
  - DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1. At that edge an extra key_press[i] strobe is emitted and the counter is cleared.
  - REPEAT: each time the counter reaches REPEAT_PERIOD-1, an extra key_press[i] strobe is emitted and the counter is cleared.
  - From DELAY or REPEAT, key_db[i] returning to 1 forces IDLE at that edge, and no repeat strobe is emitted on that edge.
  - key_db and key_release are unaffected by auto-repeat.
  - Reset forces IDLE.
- Not defined: no FSM or repeat counters are synthesized. REPEAT_DELAY and REPEAT_PERIOD are ignored. key_press strobes only on debounced 1->0.

Test Plan:
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
1. Clean press: key_raw 1111->1110 before edge 10 and held -> key_db=1110 from edge 19; key_press=0001 high only in the cycle after edge 19; key_release stays 0.
2. Bounce: key_raw[1] toggles 0/1 every 3 cycles for 30 cycles, then held 0 -> key_db[1] stays 1 during bouncing; exactly one key_press[1] strobe, 9 edges after the last transition.
3. Short glitch: key_raw[2] low for 7 cycles, then high -> key_db unchanged; no strobes.
4. Simultaneous keys: key_raw 1111->0000 at one edge, then ->1111 after 40 cycles -> key_press=1111 in a single cycle; later key_release=1111 in a single cycle.
5. Reset mid-count: key_raw[0]=0 held; reset_n pulsed low after 5 counted cycles -> key_db=1111 and strobes 0 during reset; key_db[0]=0 at edge 10 after deassert.
6. Auto-repeat (macro defined): key_raw[3] held 0 for 60 cycles after acceptance -> key_press[3] strobes at acceptance, +20, +26, +32, ...; release -> no further strobes. Macro undefined -> single strobe.
